// File: rtl/led_mode_sequencer.sv
// rtl/led_mode_sequencer.sv - push-button LED mode sequencer (OFF/ON/SLOW/FAST)
// Optional long-press-to-OFF classification: LED_SEQ_LONGPRESS_EN
module led_mode_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_250_000,
    parameter int unsigned LONG_PRESS_CYCLES = 125_000_000,
    parameter int unsigned SLOW_HALF_CYCLES  = 62_500_000,
    parameter int unsigned FAST_HALF_CYCLES  = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       button,
    output logic       led,
    output logic [1:0] mode,
    output logic       mode_change
);

    localparam int unsigned HALF_MAX = (SLOW_HALF_CYCLES > FAST_HALF_CYCLES) ?
                                       SLOW_HALF_CYCLES : FAST_HALF_CYCLES;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PH_W   = $clog2(HALF_MAX + 1);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
            $error("led_mode_sequencer: illegal debounce/long-press parameters");
        end
    endgenerate

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_e;

    logic            sync1_q, sync1_d;
    logic            btn_s_q, btn_s_d;
    logic            btn_d_q, btn_d_d;
    logic            btn_d_prev_q, btn_d_prev_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    mode_e           mode_q, mode_d;
    logic            led_q, led_d;
    logic            mode_change_q, mode_change_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic [PH_W-1:0] half_last;
    logic            short_evt;
    logic            long_evt;

`ifdef LED_SEQ_LONGPRESS_EN
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              long_fired_q, long_fired_d;
`endif

    always_comb begin
        sync1_d      = button;
        btn_s_d      = sync1_q;
        btn_d_d      = btn_d_q;
        btn_d_prev_d = btn_d_q;
        db_cnt_d     = '0;
        short_evt    = 1'b0;
        long_evt     = 1'b0;

        // Counter only runs while the synchronised level disagrees with the accepted one
        if (btn_s_q != btn_d_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_d_d  = btn_s_q;
                db_cnt_d = '0;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end

`ifdef LED_SEQ_LONGPRESS_EN
        hold_d       = hold_q;
        long_fired_d = long_fired_q;
        if (btn_d_d && !btn_d_q) begin
            hold_d       = '0;
            long_fired_d = 1'b0;
        end else if (btn_d_q && (hold_q != HOLD_W'(LONG_PRESS_CYCLES))) begin
            hold_d = hold_q + HOLD_W'(1);
        end
        long_evt  = btn_d_q && (hold_q == HOLD_W'(LONG_PRESS_CYCLES)) && !long_fired_q;
        if (long_evt) begin
            long_fired_d = 1'b1;
        end
        short_evt = !btn_d_q && btn_d_prev_q && !long_fired_q;
`else
        short_evt = btn_d_q && !btn_d_prev_q;
`endif

        mode_d = mode_q;
        if (long_evt) begin
            mode_d = MODE_OFF;
        end else if (short_evt) begin
            mode_d = mode_e'(mode_q + 2'd1);
        end
        mode_change_d = (mode_d != mode_q);

        // LED follows the next mode so it changes in the same cycle as mode
        half_last = (mode_q == MODE_SLOW) ? PH_W'(SLOW_HALF_CYCLES - 1)
                                          : PH_W'(FAST_HALF_CYCLES - 1);
        phase_d   = '0;
        led_d     = led_q;
        case (mode_d)
            MODE_OFF: led_d = 1'b0;
            MODE_ON:  led_d = 1'b1;
            MODE_SLOW, MODE_FAST: begin
                if (mode_d != mode_q) begin
                    led_d = 1'b1;
                end else if (phase_q == half_last) begin
                    led_d = ~led_q;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= 1'b0;
            btn_s_q       <= 1'b0;
            btn_d_q       <= 1'b0;
            btn_d_prev_q  <= 1'b0;
            db_cnt_q      <= '0;
            mode_q        <= MODE_OFF;
            led_q         <= 1'b0;
            mode_change_q <= 1'b0;
            phase_q       <= '0;
`ifdef LED_SEQ_LONGPRESS_EN
            hold_q        <= '0;
            long_fired_q  <= 1'b0;
`endif
        end else begin
            sync1_q       <= sync1_d;
            btn_s_q       <= btn_s_d;
            btn_d_q       <= btn_d_d;
            btn_d_prev_q  <= btn_d_prev_d;
            db_cnt_q      <= db_cnt_d;
            mode_q        <= mode_d;
            led_q         <= led_d;
            mode_change_q <= mode_change_d;
            phase_q       <= phase_d;
`ifdef LED_SEQ_LONGPRESS_EN
            hold_q        <= hold_d;
            long_fired_q  <= long_fired_d;
`endif
        end
    end

    assign led         = led_q;
    assign mode        = mode_q;
    assign mode_change = mode_change_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb/tb_led_mode_sequencer.sv - directed self-checking bench for led_mode_sequencer
module tb_led_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       button;
    logic       led;
    logic [1:0] mode;
    logic       mode_change;

    int tests_run    = 0;
    int tests_failed = 0;

    always #4 clk = ~clk;

    led_mode_sequencer #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .SLOW_HALF_CYCLES (8),
        .FAST_HALF_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .button     (button),
        .led        (led),
        .mode       (mode),
        .mode_change(mode_change)
    );

    // Press at k=0 (just after an edge), release just after edge k=hold; sample #1 after each edge
    task automatic do_press(input int hold, input int window,
                            output int pulses, output int first_k, output logic led_at);
        pulses  = 0;
        first_k = -1;
        led_at  = 1'b0;
        button  = 1'b1;
        for (int k = 1; k <= window; k++) begin
            @(posedge clk);
            #1;
            if (mode_change === 1'b1) begin
                pulses++;
                if (first_k < 0) begin
                    first_k = k;
                    led_at  = led;
                end
            end
            if (k == hold) button = 1'b0;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        button = 1'b0;
        rst_n  = 1'b0;
        #3;
        tests_run++;
        if (led !== 1'b0) begin tests_failed++; $display("FAIL reset_led: got %0b expected 0", led); end
        tests_run++;
        if (mode !== 2'd0) begin tests_failed++; $display("FAIL reset_mode: got %0d expected 0", mode); end
        tests_run++;
        if (mode_change !== 1'b0) begin tests_failed++; $display("FAIL reset_mode_change: got %0b expected 0", mode_change); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (mode_change !== 1'b0 || led !== 1'b0 || mode !== 2'd0) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL reset_idle_100: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_glitch();
        int p, f;
        logic l;
        do_press(3, 30, p, f, l);
        tests_run++;
        if (p != 0) begin tests_failed++; $display("FAIL glitch_pulses: got %0d expected 0", p); end
        tests_run++;
        if (mode !== 2'd0) begin tests_failed++; $display("FAIL glitch_mode: got %0d expected 0", mode); end
    endtask

    task automatic test_short_presses();
        int p, f, exp_k;
        logic l;
        logic [1:0] exp_mode [4];
        logic       exp_led  [4];
        exp_mode = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_led  = '{1'b1, 1'b1, 1'b1, 1'b0};
`ifdef LED_SEQ_LONGPRESS_EN
        exp_k = 17;
`else
        exp_k = 7;
`endif
        for (int i = 0; i < 4; i++) begin
            do_press(10, 20, p, f, l);
            tests_run++;
            if (p != 1) begin tests_failed++; $display("FAIL press%0d_pulses: got %0d expected 1", i, p); end
            tests_run++;
            if (f != exp_k) begin tests_failed++; $display("FAIL press%0d_latency: got %0d expected %0d", i, f, exp_k); end
            tests_run++;
            if (mode !== exp_mode[i]) begin tests_failed++; $display("FAIL press%0d_mode: got %0d expected %0d", i, mode, exp_mode[i]); end
            tests_run++;
            if (l !== exp_led[i]) begin tests_failed++; $display("FAIL press%0d_led: got %0b expected %0b", i, l, exp_led[i]); end
        end
    endtask

`ifdef LED_SEQ_LONGPRESS_EN
    task automatic test_long_press();
        int p, f;
        logic l;
        do_press(10, 20, p, f, l);
        do_press(10, 20, p, f, l);
        tests_run++;
        if (mode !== 2'd2) begin tests_failed++; $display("FAIL long_setup_mode: got %0d expected 2", mode); end
        do_press(40, 60, p, f, l);
        tests_run++;
        if (p != 1) begin tests_failed++; $display("FAIL long_pulses: got %0d expected 1", p); end
        tests_run++;
        if (f != 27) begin tests_failed++; $display("FAIL long_latency: got %0d expected 27", f); end
        tests_run++;
        if (mode !== 2'd0) begin tests_failed++; $display("FAIL long_mode: got %0d expected 0", mode); end
    endtask
`else
    task automatic test_rise_advance();
        int p, f;
        logic l;
        apply_reset();
        do_press(10, 20, p, f, l);
        tests_run++;
        if (f != 7) begin tests_failed++; $display("FAIL rise_latency: got %0d expected 7", f); end
        tests_run++;
        if (p != 1) begin tests_failed++; $display("FAIL rise_pulses: got %0d expected 1", p); end
        tests_run++;
        if (mode !== 2'd1) begin tests_failed++; $display("FAIL rise_mode: got %0d expected 1", mode); end
    endtask
`endif

    task automatic test_blink();
        int p, f, bad, j;
        logic l, exp_l;
        apply_reset();
        do_press(10, 20, p, f, l);
        tests_run++;
        if (mode !== 2'd1) begin tests_failed++; $display("FAIL blink_on_mode: got %0d expected 1", mode); end
        do_press(10, 20, p, f, l);
        tests_run++;
        if (mode !== 2'd2) begin tests_failed++; $display("FAIL blink_slow_mode: got %0d expected 2", mode); end
        tests_run++;
        if (l !== 1'b1) begin tests_failed++; $display("FAIL blink_slow_entry_led: got %0b expected 1", l); end
        bad = 0;
        for (int m = 1; m <= 32; m++) begin
            @(posedge clk);
            #1;
            j = (20 - f) + m;
            exp_l = ((j / 8) % 2) == 0;
            if (led !== exp_l) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL blink_slow_pattern: got %0d bad cycles expected 0", bad); end
        do_press(10, 20, p, f, l);
        tests_run++;
        if (mode !== 2'd3) begin tests_failed++; $display("FAIL blink_fast_mode: got %0d expected 3", mode); end
        tests_run++;
        if (l !== 1'b1) begin tests_failed++; $display("FAIL blink_fast_entry_led: got %0b expected 1", l); end
        bad = 0;
        for (int m = 1; m <= 16; m++) begin
            @(posedge clk);
            #1;
            j = (20 - f) + m;
            exp_l = ((j / 2) % 2) == 0;
            if (led !== exp_l) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL blink_fast_pattern: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid_blink();
        tests_run++;
        if (mode !== 2'd3) begin tests_failed++; $display("FAIL midreset_pre_mode: got %0d expected 3", mode); end
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (led !== 1'b0) begin tests_failed++; $display("FAIL midreset_led: got %0b expected 0", led); end
        tests_run++;
        if (mode !== 2'd0) begin tests_failed++; $display("FAIL midreset_mode: got %0d expected 0", mode); end
        tests_run++;
        if (mode_change !== 1'b0) begin tests_failed++; $display("FAIL midreset_mode_change: got %0b expected 0", mode_change); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_short_presses();
`ifdef LED_SEQ_LONGPRESS_EN
        test_long_press();
`else
        test_rise_advance();
`endif
        test_blink();
        test_reset_mid_blink();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
